// File: rtl/mult_share_pkg.sv
// Shared types for the multiplier-sharing arbiter.
// Optional accept counters: MULT_SHARE_PERF_EN.
package mult_share_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_WIDTH    = 64;
  localparam int DEF_MULT_LAT = 1;
  localparam int MAX_REQ      = 8;
  localparam int ID_W         = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_BUSY,
    SLOT_DONE
  } slot_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin one-hot grant with a registered search pointer.
// The pointer moves past the winner only when something is granted.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k == i) ||
             (int'(ptr) + k == i + NUM_REQ))) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          ptr_nxt = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (found) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one registered multiplier among NUM_REQ requesters.
// Optional per-requester accept counters: MULT_SHARE_PERF_EN.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [NUM_REQ*2*WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_p
`ifdef MULT_SHARE_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]      grant_cnt
`endif
);

  localparam int PW = 2 * WIDTH;

  slot_e              st     [NUM_REQ];
  slot_e              st_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] hit;
  logic               accept;
  logic [ID_W-1:0]    gid;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  tag_t               pipe [MULT_LAT+1];
  tag_t               ex;

  // Reset gates eligibility so req_ready reads zero while rst_n is low.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = rst_n && req_valid[i] &&
                (st[i] == SLOT_IDLE);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    gid   = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gid   = ID_W'(i);
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= sel_a;
      mul_b <= sel_b;
    end
  end

  // Tag ages in step with the operand through the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= MULT_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{valid: accept, id: gid};
      for (int k = 1; k <= MULT_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign ex = pipe[MULT_LAT];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      hit[i]    = ex.valid && (ex.id == ID_W'(i));
      st_nxt[i] = st[i];
      unique case (st[i])
        SLOT_IDLE: if (gnt[i]) st_nxt[i] = SLOT_BUSY;
        SLOT_BUSY: if (hit[i]) st_nxt[i] = SLOT_DONE;
        SLOT_DONE: if (rsp_ready[i]) st_nxt[i] = SLOT_IDLE;
        default:   st_nxt[i] = SLOT_IDLE;
      endcase
      rsp_valid[i] = (st[i] == SLOT_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) st[i] <= SLOT_IDLE;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) st[i] <= st_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hit[i] && st[i] == SLOT_BUSY)
          rsp_data[i*PW +: PW] <= mul_p;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
    a_busy: assert property (
      @(posedge clk) disable iff (!rst_n)
      hit[g] |-> st[g] == SLOT_BUSY);
  end

`ifdef MULT_SHARE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`else
  // Accept counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter with a transaction-level
// model of requester ownership, round-robin order and products.
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '0;
  logic [N*2*W-1:0] rsp_data;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_p = '0;
`ifdef MULT_SHARE_PERF_EN
  logic [N*32-1:0]  grant_cnt;
`endif

  mult_share_arbiter #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .MULT_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
`ifdef MULT_SHARE_PERF_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // External one-stage multiplier instance.
  always @(posedge clk) mul_p <= {64'b0, mul_a} * {64'b0, mul_b};

  int n_vec = 0;
  int n_err = 0;

  bit           out_m   [N];
  int           done_at [N];
  logic [127:0] exp_m   [N];
  logic [127:0] data_m  [N];
  int           gcnt_m  [N];
  logic [63:0]  opa     [N];
  logic [63:0]  opb     [N];
  logic [63:0]  ma, mb;
  int           ptr_m;
  int           cyc = 0;
  int           last_w;

  function automatic logic [63:0] rnd64();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '1;
    if (r == 1) return '0;
    return {$urandom, $urandom};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = rnd64();
      opb[i] = rnd64();
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      out_m[i]  = 1'b0;
      data_m[i] = '0;
      gcnt_m[i] = 0;
    end
    ma = '0;
    mb = '0;
    ptr_m = 0;
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rr);
    int w;
    logic [N-1:0] er;
    logic [N-1:0] rv;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        req_a[i*W +: W] = opa[i];
        req_b[i*W +: W] = opb[i];
      end else begin
        req_a[i*W +: W] = 'x;
        req_b[i*W +: W] = 'x;
      end
    end
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (w < 0 && v[j] && !out_m[j]) w = j;
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    n_vec++;
    if (req_ready !== er) begin
      n_err++;
      $display("FAIL req_ready cyc %0d got %b exp %b", cyc, req_ready, er);
    end
    last_w = -1;
    for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) last_w = i;
    for (int i = 0; i < N; i++) begin
      rv[i] = out_m[i] && (cyc >= done_at[i]);
      if (rv[i]) data_m[i] = exp_m[i];
      n_vec++;
      if (rsp_valid[i] !== rv[i]) begin
        n_err++;
        $display("FAIL rsp_valid[%0d] cyc %0d got %b exp %b",
                 i, cyc, rsp_valid[i], rv[i]);
      end
      n_vec++;
      if (rsp_data[i*128 +: 128] !== data_m[i]) begin
        n_err++;
        $display("FAIL rsp_data[%0d] cyc %0d got %h exp %h",
                 i, cyc, rsp_data[i*128 +: 128], data_m[i]);
      end
    end
    n_vec++;
    if (mul_a !== ma || mul_b !== mb) begin
      n_err++;
      $display("FAIL mul_ab cyc %0d got %h/%h exp %h/%h",
               cyc, mul_a, mul_b, ma, mb);
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (rv[i] && rr[i]) out_m[i] = 1'b0;
    if (w >= 0) begin
      out_m[w]   = 1'b1;
      done_at[w] = cyc + LAT + 1;
      exp_m[w]   = {64'b0, opa[w]} * {64'b0, opb[w]};
      ma         = opa[w];
      mb         = opb[w];
      ptr_m      = (w + 1) % N;
      gcnt_m[w]++;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = v;
    rsp_ready = '1;
    #1;
    n_vec++;
    if (req_ready !== '0 || rsp_valid !== '0) begin
      n_err++;
      $display("FAIL reset_hs got rdy %b vld %b exp 0/0", req_ready, rsp_valid);
    end
    n_vec++;
    if (rsp_data !== '0) begin
      n_err++;
      $display("FAIL reset_data got %h exp 0", rsp_data);
    end
    n_vec++;
    if (mul_a !== '0 || mul_b !== '0) begin
      n_err++;
      $display("FAIL reset_mul got %h/%h exp 0/0", mul_a, mul_b);
    end
    model_clear();
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_reset();
    do_reset('1);
  endtask

  task automatic test_single();
    opa[0] = 64'd3;
    opb[0] = 64'd5;
    step(4'b0001, '1);
    n_vec++;
    if (last_w != 0) begin
      n_err++;
      $display("FAIL single_grant got %0d exp 0", last_w);
    end
    for (int k = 0; k < 3; k++) step('0, '1);
    #1;
    n_vec++;
    if (rsp_data[0 +: 128] !== 128'd15) begin
      n_err++;
      $display("FAIL single_prod got %h exp %h", rsp_data[0 +: 128], 128'd15);
    end
  endtask

  task automatic test_max();
    opa[2] = '1;
    opb[2] = '1;
    step(4'b0100, '1);
    for (int k = 0; k < 3; k++) step('0, '1);
    #1;
    n_vec++;
    if (rsp_data[256 +: 128] !==
        128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      n_err++;
      $display("FAIL max_prod got %h exp fffffffffffffffe0000000000000001",
               rsp_data[256 +: 128]);
    end
  endtask

  task automatic test_round_robin();
    do_reset('0);
    for (int k = 0; k < 16; k++) begin
      rand_ops();
      step('1, '1);
      n_vec++;
      if (last_w != k % N) begin
        n_err++;
        $display("FAIL rr_order step %0d got %0d exp %0d", k, last_w, k % N);
      end
    end
  endtask

  task automatic test_back_to_back();
    int g1;
    g1 = 0;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      step('1, 4'b1101);
      if (last_w == 1) g1++;
    end
    n_vec++;
    if (g1 > 1) begin
      n_err++;
      $display("FAIL bp_regrant got %0d grants exp at most 1", g1);
    end
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      step('1, '1);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset('0);
    rand_ops();
    step(4'b1000, '1);
    do_reset(4'b1000);
    for (int k = 0; k < 6; k++) step('0, '1);
    #1;
    n_vec++;
    if (rsp_valid !== '0) begin
      n_err++;
      $display("FAIL midflight got %b exp 0000", rsp_valid);
    end
  endtask

  task automatic test_random();
    do_reset('0);
    for (int k = 0; k < 300; k++) begin
      rand_ops();
      step(N'($urandom), N'($urandom | $urandom));
    end
    for (int k = 0; k < 5; k++) step('0, '1);
  endtask

`ifdef MULT_SHARE_PERF_EN
  task automatic test_perf();
    do_reset('0);
    for (int k = 0; k < 40 && gcnt_m[0] < 5; k++) begin
      rand_ops();
      step(4'b0001, '1);
    end
    for (int k = 0; k < 40 && gcnt_m[1] < 2; k++) begin
      rand_ops();
      step(4'b0010, '1);
    end
    step('0, '1);
    #1;
    n_vec++;
    if (grant_cnt !== {32'd0, 32'd0, 32'd2, 32'd5}) begin
      n_err++;
      $display("FAIL grant_cnt got %h exp %h", grant_cnt,
               {32'd0, 32'd0, 32'd2, 32'd5});
    end
  endtask
`endif

  initial begin
    model_clear();
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
      done_at[i] = 0;
      exp_m[i] = '0;
    end
    test_reset();
    test_single();
    test_max();
    test_round_robin();
    test_back_to_back();
    test_reset_midflight();
    test_random();
`ifdef MULT_SHARE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
